// File: rtl/exec_writeback_unit_if.sv
// Execute-stage bus: operand/request inputs from the sequencer and register
// file read ports, completion handshake and register-file write port outputs.
interface exec_writeback_unit_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic [3:0]        op;
  logic [ADDR_W-1:0] rd;
  logic [WIDTH-1:0]  busA;
  logic [WIDTH-1:0]  busB;
  logic              busy;
  logic              done;
  logic              err;
  logic              zero;
  logic              carry;
  logic [WIDTH-1:0]  busD;
  logic [ADDR_W-1:0] regAddrD;
  logic              regWeD;

  modport master (
    output start, op, rd, busA, busB,
    input  busy, done, err, zero, carry, busD, regAddrD, regWeD
  );

  modport slave (
    input  start, op, rd, busA, busB,
    output busy, done, err, zero, carry, busD, regAddrD, regWeD
  );
endinterface

// File: rtl/exec_writeback_unit.sv
// Execute/write-back stage: single-cycle logic ops, iterative shifts and
// shift-add multiply, one write-back pulse per accepted operation.
module exec_writeback_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rstN,
  exec_writeback_unit_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, ITER, WB} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7
  } opcode_t;

  state_t            state;
  logic [3:0]        opR;
  logic [ADDR_W-1:0] rdR;
  logic [WIDTH-1:0]  opA, opB, acc;
  logic [CNT_W-1:0]  count;

  logic              isAlu, isShift, isIllegal, shiftZero, commitNow;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  aluRes, iterRes, resVal;
  logic              aluCarry, iterOut, resCarry;

  always_comb begin
    isAlu     = (opR <= OP_XOR);
    isShift   = (opR == OP_SHL) || (opR == OP_SHR);
    isIllegal = (opR > OP_MUL);
    shiftZero = isShift && (opB[3:0] == 4'd0);
    sum       = {1'b0, opA} + {1'b0, opB};

    aluRes   = '0;
    aluCarry = 1'b0;
    case (opR)
      OP_ADD: begin aluRes = sum[WIDTH-1:0]; aluCarry = sum[WIDTH]; end
      OP_SUB: begin aluRes = opA - opB;      aluCarry = (opA < opB); end
      OP_AND: aluRes = opA & opB;
      OP_OR:  aluRes = opA | opB;
      OP_XOR: aluRes = opA ^ opB;
      default: ;
    endcase

    // ITER step: shifts move opA in place; MUL adds the shifted multiplicand
    // into acc for each set bit of the right-shifting multiplier in opB.
    iterRes = '0;
    iterOut = 1'b0;
    case (opR)
      OP_SHL: begin iterRes = {opA[WIDTH-2:0], 1'b0}; iterOut = opA[WIDTH-1]; end
      OP_SHR: begin iterRes = {1'b0, opA[WIDTH-1:1]}; iterOut = opA[0]; end
      OP_MUL: iterRes = acc + (opB[0] ? opA : '0);
      default: ;
    endcase

    commitNow = ((state == EXEC) && (isAlu || shiftZero)) ||
                ((state == ITER) && (count == CNT_W'(1)));
    resVal    = (state == ITER) ? iterRes : (isShift ? opA : aluRes);
    resCarry  = (state == ITER) ? iterOut : (isShift ? 1'b0 : aluCarry);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state        <= IDLE;
      opR          <= '0;
      rdR          <= '0;
      opA          <= '0;
      opB          <= '0;
      acc          <= '0;
      count        <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.zero     <= 1'b0;
      bus.carry    <= 1'b0;
      bus.busD     <= '0;
      bus.regAddrD <= '0;
      bus.regWeD   <= 1'b0;
    end else begin
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.regWeD <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opR      <= bus.op;
            rdR      <= bus.rd;
            opA      <= bus.busA;
            opB      <= bus.busB;
            bus.busy <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (isIllegal) begin
            bus.busD     <= '0;
            bus.regAddrD <= rdR;
            bus.err      <= 1'b1;
            bus.done     <= 1'b1;
            state        <= WB;
          end else if (isShift) begin
            count <= CNT_W'(opB[3:0]);
            state <= ITER;
          end else if (opR == OP_MUL) begin
            acc   <= '0;
            count <= CNT_W'(WIDTH);
            state <= ITER;
          end
        end
        ITER: begin
          if (opR == OP_MUL) begin
            acc <= iterRes;
            opA <= opA << 1;
            opB <= opB >> 1;
          end else begin
            opA <= iterRes;
          end
          count <= count - CNT_W'(1);
        end
        WB: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Shared commit path: overrides the EXEC/ITER next-state above.
      if (commitNow) begin
        bus.busD     <= resVal;
        bus.regAddrD <= rdR;
        bus.zero     <= (resVal == '0);
        bus.carry    <= resCarry;
        bus.done     <= 1'b1;
        bus.regWeD   <= (rdR != '0);
        state        <= WB;
      end
    end
  end
endmodule

// File: tb/tb_exec_writeback_unit.sv
// Directed bench for exec_writeback_unit with a scoreboard of expected
// write-backs checked whenever done is observed.
module tb_exec_writeback_unit;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   weCount = 0;
  int   expWe = 0;
  logic lastZ = 1'b0;
  logic lastC = 1'b0;

  typedef struct {
    string       tag;
    logic [15:0] d;
    logic [4:0]  a;
    logic        we, er, z, c;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  exec_writeback_unit_if #(.WIDTH(16), .ADDR_W(5)) bus ();
  exec_writeback_unit #(.WIDTH(16), .ADDR_W(5)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c, output int lat);
    logic [16:0] s;
    logic [31:0] p;
    int k;
    k = int'(b[3:0]);
    r = '0; c = 1'b0; lat = 2;
    case (o)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin r = a << k; c = (k != 0) ? a[16-k] : 1'b0; lat = 2 + k; end
      4'd6: begin r = a >> k; c = (k != 0) ? a[k-1] : 1'b0; lat = 2 + k; end
      4'd7: begin p = a * b; r = p[15:0]; lat = 18; end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [3:0] o, input logic [4:0] r, input logic [15:0] a,
                       input logic [15:0] b, input string tag, input bit expectWb = 1'b1);
    exp_t e;
    logic [15:0] res;
    logic c;
    int lat;
    @(negedge clk);
    bus.op = o; bus.rd = r; bus.busA = a; bus.busB = b; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    if (expectWb) begin
      model(o, a, b, res, c, lat);
      e.tag = tag; e.a = r; e.lat = lat; e.acc = cyc;
      if (o > 4'd7) begin
        e.d = '0; e.we = 1'b0; e.er = 1'b1; e.z = lastZ; e.c = lastC;
      end else begin
        e.d = res; e.we = (r != 5'd0); e.er = 1'b0; e.z = (res == 16'd0); e.c = c;
        lastZ = e.z; lastC = e.c;
      end
      if (e.we) expWe++;
      sb.push_back(e);
    end
  endtask

  task automatic waitIdle(input string tag);
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy) begin
        drained = 1'b1;
        break;
      end
    end
    chk({tag, "_drain"}, 32'(drained), 32'd1);
  endtask

  always @(negedge clk) begin
    if (bus.regWeD) weCount++;
    if (bus.done) begin
      chk("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_busD"},     32'(bus.busD),     32'(e.d));
        chk({e.tag, "_regAddrD"}, 32'(bus.regAddrD), 32'(e.a));
        chk({e.tag, "_regWeD"},   32'(bus.regWeD),   32'(e.we));
        chk({e.tag, "_err"},      32'(bus.err),      32'(e.er));
        chk({e.tag, "_zero"},     32'(bus.zero),     32'(e.z));
        chk({e.tag, "_carry"},    32'(bus.carry),    32'(e.c));
        chk({e.tag, "_latency"},  32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.rd = '0; bus.busA = '0; bus.busB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {bus.busy, bus.done, bus.err, bus.zero, bus.carry, bus.regWeD, bus.busD, bus.regAddrD},
        32'd0);
    @(negedge clk);
    rstN = 1'b1;

    issue(4'd0, 5'd3, 16'd313, 16'd7, "add");               waitIdle("add");
    issue(4'd1, 5'd4, 16'd5, 16'd9, "sub");                 waitIdle("sub");
    issue(4'd0, 5'd2, 16'hFFFF, 16'd1, "add_wrap");         waitIdle("add_wrap");
    issue(4'd9, 5'd9, 16'h1234, 16'h5678, "illegal");       waitIdle("illegal");
    issue(4'd5, 5'd6, 16'h8001, 16'd1, "shl1");             waitIdle("shl1");
    issue(4'd6, 5'd7, 16'h00F0, 16'd4, "shr4");             waitIdle("shr4");
    issue(4'd5, 5'd8, 16'h1234, 16'd0, "shl0");             waitIdle("shl0");
    issue(4'd6, 5'd10, 16'hA5C3, 16'h00FF, "shr15");        waitIdle("shr15");
    issue(4'd2, 5'd11, 16'hF0F0, 16'h3C3C, "and");          waitIdle("and");
    issue(4'd3, 5'd12, 16'hF000, 16'h000F, "or");           waitIdle("or");
    issue(4'd4, 5'd13, 16'hAAAA, 16'hAAAA, "xor");          waitIdle("xor");

    issue(4'd7, 5'd5, 16'd300, 16'd300, "mul");
    repeat (4) @(negedge clk);
    bus.op = 4'd0; bus.rd = 5'd14; bus.busA = 16'd1; bus.busB = 16'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitIdle("mul");

    issue(4'd0, 5'd0, 16'd1, 16'd1, "add_r0");
    @(negedge clk);
    @(negedge clk);
    chk("wb_done", 32'(bus.done), 32'd1);
    chk("wb_busy", 32'(bus.busy), 32'd1);
    bus.op = 4'd0; bus.rd = 5'd15; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("after_wb_busy", 32'(bus.busy), 32'd0);
    waitIdle("add_r0");

    issue(4'd7, 5'd16, 16'd123, 16'd45, "mul_abort", 1'b0);
    repeat (5) @(negedge clk);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_state", {29'd0, bus.busy, bus.done, bus.regWeD}, 32'd0);
    chk("abort_busD", 32'(bus.busD), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    lastZ = 1'b0; lastC = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 32'd0);

    issue(4'd0, 5'd17, 16'd1000, 16'd24, "add_post");       waitIdle("add_post");

    repeat (2) @(negedge clk);
    chk("regWeD_pulses", 32'(weCount), 32'(expWe));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
